// File: rtl/imem_loader.sv
// Boot-time program loader: receives a framed image (header, N words, checksum)
// over a valid/ready stream, writes it to instruction memory and releases the core on success.
module imem_loader #(
  parameter int          DEPTH = 64,
  parameter int          AW    = 6,
  parameter logic [15:0] MAGIC = 16'hB007
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_reset,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_HDR,
    S_LOAD,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_n;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_sum;

  logic          w_accept;
  logic          w_hdrOk;
  logic          w_lastWord;
  logic [31:0]   w_sumNext;

  assign in_ready   = !reset && (r_state == S_HDR || r_state == S_LOAD || r_state == S_CSUM);
  assign w_accept   = in_valid && in_ready;
  assign w_hdrOk    = (in_data[31:16] == MAGIC) && (in_data[15:0] != 16'd0) &&
                      ({1'b0, in_data[15:0]} <= LP_DEPTH);
  assign w_lastWord = ({{(16-AW){1'b0}}, r_idx} == (r_n - 16'd1));
  assign w_sumNext  = r_sum + in_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR:   if (w_accept) w_next = w_hdrOk ? S_LOAD : S_ERR;
      S_LOAD:  if (w_accept && w_lastWord) w_next = S_CSUM;
      S_CSUM:  if (w_accept) w_next = (w_sumNext == 32'd0) ? S_RUN : S_ERR;
      S_RUN:   w_next = S_RUN;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
  end

  // Index holds at N-1 after the last word so it can never wrap past DEPTH-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_HDR;
      r_n        <= 16'd0;
      r_idx      <= '0;
      r_sum      <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      core_reset <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_next;
      imem_we    <= 1'b0;
      core_reset <= (w_next != S_RUN);
      done       <= (w_next == S_RUN);
      err        <= (w_next == S_ERR);
      if (w_accept) begin
        case (r_state)
          S_HDR: begin
            if (w_hdrOk) begin
              r_n   <= in_data[15:0];
              r_idx <= '0;
              r_sum <= in_data;
            end
          end
          S_LOAD: begin
            imem_we    <= 1'b1;
            imem_addr  <= r_idx;
            imem_wdata <= in_data;
            r_sum      <= w_sumNext;
            if (!w_lastWord) r_idx <= r_idx + {{(AW-1){1'b0}}, 1'b1};
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader between an external word stream (host/UART deserializer) and the instruction memory of the single-cycle MIPS core. After reset it accepts a framed program image over a valid/ready stream, writes each word into the instruction memory write port, and verifies a checksum. It holds the core in reset until the image is accepted, and releases it only on success. It is the stage directly upstream of instruction fetch.

## Interface
- DEPTH, 64: instruction memory depth in words; maximum image length.
- AW, 6: instruction memory word-address width; requires 2^AW >= DEPTH.
- MAGIC, 16'hB007: required value of header bits [31:16].

- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; returns block to HDR state.
- in_valid  in  1  stream word present.
- in_ready  out  1  loader can accept; combinational from state only (1 in HDR, LOAD, CSUM).
- in_data  in  32  stream word; must hold stable while in_valid=1 and in_ready=0.
- imem_we  out  1  registered one-cycle write strobe to instruction memory.
- imem_addr  out  AW  registered word address of the write.
- imem_wdata  out  32  registered write data.
- core_reset  out  1  registered; 1 holds the core (PC register) in reset.
- done  out  1  registered; image loaded and verified (sticky).
- err  out  1  registered; framing or checksum failure (sticky).

## Operation
- Transfer occurs on a rising edge where in_valid & in_ready = 1 ("accept").
- Frame: header word, then N data words, then one checksum word.
- Header: [31:16] = MAGIC, [15:0] = N. Valid iff magic matches and 1 <= N <= DEPTH.
- States: HDR, LOAD, CSUM, RUN, ERR.
  - HDR: on accept of a valid header, latch N, clear index to 0, set sum = header, go to LOAD. On an invalid header, go to ERR.
  - LOAD: on accept, write the word at address index, increment index, and add the word to sum (32-bit, wrap mod 2^32). When the accepted word is the Nth (index == N-1), go to CSUM.
  - CSUM: on accept, if (sum + word) mod 2^32 == 0, go to RUN; else go to ERR. No memory write occurs.
  - RUN: core_reset=0, done=1, in_ready=0. Terminal until reset.
  - ERR: err=1, core_reset=1, in_ready=0. Terminal until reset.
- Any cycle without an accept leaves the state, index and sum unchanged. Stalls of any length are allowed in any state.
- Addresses are written strictly in order 0..N-1. Words at N..DEPTH-1 are untouched.
- A failed checksum leaves the already-written words in memory; the core is still not released.

## Timing
- Reset values: in_ready=0 while reset is high, then 1 (HDR); imem_we=0; imem_addr=0; imem_wdata=0; core_reset=1; done=0; err=0; index=0; sum=0.
- Write latency: the data word accepted at edge k appears on imem_addr/imem_wdata with imem_we=1 during the cycle after edge k, and commits at edge k+1. One strobe per accepted word. Back-to-back accepts give back-to-back strobes.
- The final data write commits at the same edge as the checksum accept, or earlier.
- core_reset falls and done rises at the edge that accepts a good checksum word. The core's first fetch from address 0 follows at the next edge, after the last write has committed.
- err rises at the edge that accepts the offending header or checksum word.
- Throughput: 1 word per cycle; in_ready never drops inside HDR, LOAD or CSUM.
- Reset asserted mid-load: immediate return to reset values and HDR. Any partial image is abandoned, and a new frame must start with a header.
- N == DEPTH: the last write goes to address DEPTH-1. The index never wraps.

## Test plan
- Good image, no stalls: header 32'hB0070003, data 20020005, 2003000C, 2067FFF7, checksum EF8BFFF5 -> strobes to addr 0,1,2 with those words in consecutive cycles; core_reset falls and done=1 at the checksum edge; err=0.
- Same image with in_valid gaps of 0–5 random cycles -> identical writes and result; no strobes during gaps.
- Bad header: 32'hB0080003, then 32'hB0070000, then 32'hB0070041 (DEPTH=64), each after reset -> err=1 at the header edge; no imem_we; core_reset stays 1; in_ready=0.
- Bad checksum: the good image with checksum EF8BFFF6 -> three writes occur; err=1; done=0; core_reset=1.
- Full depth: N=64 with random words and the correct checksum -> 64 writes to addr 0..63, then done=1.
- Reset mid-load: reset pulse after the 2nd data word, then a full good frame -> outputs return to reset values during the pulse; the new frame loads from addr 0 and done=1.
